// File: rtl/decrypt_6blocks_128_if.sv
// Request/response bundle for the single-block Ascon-128 decryption core.
// The master side drives request data; the slave side (the core) returns results.
interface decrypt_6blocks_128_if;
    logic         start;
    logic [127:0] SK;
    logic [127:0] N;
    logic [63:0]  A;
    logic [63:0]  C;
    logic [127:0] T;
    logic         busy;
    logic         done;
    logic         valid;
    logic [63:0]  P;
    logic [127:0] Tc;

    modport master (
        output start, SK, N, A, C, T,
        input  busy, done, valid, P, Tc
    );

    modport slave (
        input  start, SK, N, A, C, T,
        output busy, done, valid, P, Tc
    );
endinterface

// File: rtl/decrypt_6blocks_128.sv
// Single-block Ascon-128 decryption with tag check; one unrolled 6-round pass per
// clock, same state schedule as the single-block encryptor so its (C, T) round-trips.
module decrypt_6blocks_128 (
    input  logic clk,
    input  logic reset,
    decrypt_6blocks_128_if.slave bus
);
    localparam logic [63:0] IV = 64'h80400c0600000000;

    typedef enum logic [2:0] {IDLE, INIT1, INIT2, AD, CT, FIN1, FIN2} state_t;

    state_t       r_state, w_next;
    logic [319:0] r_s;
    logic [127:0] r_sk, r_t, r_tc;
    logic [63:0]  r_a, r_c, r_pint, r_p;
    logic         r_done, r_valid;
    logic [319:0] w_p6_in, w_p6;
    logic [127:0] w_tcalc;
    logic         w_match;

    function automatic logic [63:0] f_ror(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Round constants step down by 0x0f: 96, 87, 78, 69, 5a, 4b.
    function automatic logic [319:0] f_p6(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        for (int unsigned r = 0; r < 6; r++) begin
            x2 = x2 ^ {56'h0, 8'h96 - 8'(r * 15)};
            x0 = x0 ^ x4;  x4 = x4 ^ x3;  x2 = x2 ^ x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 = x0 ^ t1;  x1 = x1 ^ t2;  x2 = x2 ^ t3;  x3 = x3 ^ t4;  x4 = x4 ^ t0;
            x1 = x1 ^ x0;  x0 = x0 ^ x4;  x3 = x3 ^ x2;  x2 = ~x2;
            x0 = x0 ^ f_ror(x0, 19) ^ f_ror(x0, 28);
            x1 = x1 ^ f_ror(x1, 61) ^ f_ror(x1, 39);
            x2 = x2 ^ f_ror(x2, 1)  ^ f_ror(x2, 6);
            x3 = x3 ^ f_ror(x3, 10) ^ f_ror(x3, 17);
            x4 = x4 ^ f_ror(x4, 7)  ^ f_ror(x4, 41);
        end
        return {x0, x1, x2, x3, x4};
    endfunction

    // In CT the ciphertext replaces s0 before the permutation.
    always_comb begin
        w_p6_in = (r_state == CT) ? {r_c, r_s[255:0]} : r_s;
        w_p6    = f_p6(w_p6_in);
        w_tcalc = w_p6[127:0] ^ r_sk;
        w_match = (w_tcalc == r_t);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = INIT1;
            INIT1:   w_next = INIT2;
            INIT2:   w_next = AD;
            AD:      w_next = CT;
            CT:      w_next = FIN1;
            FIN1:    w_next = FIN2;
            FIN2:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_p     <= '0;
            r_tc    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_s  <= {IV, bus.SK, bus.N};
                    r_sk <= bus.SK;
                    r_a  <= bus.A;
                    r_c  <= bus.C;
                    r_t  <= bus.T;
                end
                INIT1, FIN1: r_s <= w_p6;
                INIT2: r_s <= w_p6 ^ {r_a, 128'h0, r_sk};
                AD:    r_s <= w_p6 ^ {319'h0, 1'b1};
                CT: begin
                    r_pint <= r_s[319:256] ^ r_c;
                    r_s    <= w_p6 ^ {64'h0, r_sk, 128'h0};
                end
                FIN2: begin
                    r_tc    <= w_tcalc;
                    r_valid <= w_match;
                    r_p     <= w_match ? r_pint : '0;
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (r_state != IDLE);
    assign bus.done  = r_done;
    assign bus.valid = r_valid;
    assign bus.P     = r_p;
    assign bus.Tc    = r_tc;
endmodule

// File: tb/tb_decrypt_6blocks_128.sv
// Bench for decrypt_6blocks_128: vector table from a table-driven Ascon model
// (S-box lookup per bit column) plus hand-written handshake corner sequences.
module tb_decrypt_6blocks_128;
    localparam logic [63:0] IV = 64'h80400c0600000000;
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam logic [7:0] RC [6] = '{8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
    localparam int ROTA [5] = '{19, 61, 1, 10, 7};
    localparam int ROTB [5] = '{28, 39, 6, 17, 41};

    typedef struct {
        logic [127:0] k;
        logic [127:0] n;
        logic [63:0]  a;
        logic [63:0]  c;
        logic [127:0] t;
        logic         ev;
        logic [63:0]  ep;
        logic [127:0] etc;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    decrypt_6blocks_128_if bus ();
    decrypt_6blocks_128 dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [63:0] m_rot(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [319:0] m_perm(input logic [319:0] s);
        logic [63:0] w [5];
        logic [63:0] o [5];
        logic [4:0]  col, sb;
        for (int i = 0; i < 5; i++) w[i] = s[319 - 64 * i -: 64];
        for (int r = 0; r < 6; r++) begin
            w[2][7:0] = w[2][7:0] ^ RC[r];
            for (int b = 0; b < 64; b++) begin
                col = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
                sb  = SBOX[col];
                for (int i = 0; i < 5; i++) o[i][b] = sb[4 - i];
            end
            for (int i = 0; i < 5; i++) w[i] = o[i] ^ m_rot(o[i], ROTA[i]) ^ m_rot(o[i], ROTB[i]);
        end
        return {w[0], w[1], w[2], w[3], w[4]};
    endfunction

    // dec=0: din is plaintext, dout ciphertext; dec=1: din is ciphertext, dout plaintext.
    function automatic void m_ascon(input logic [127:0] k, input logic [127:0] n,
                                    input logic [63:0] a, input logic [63:0] din, input logic dec,
                                    output logic [63:0] dout, output logic [127:0] tag);
        logic [319:0] s;
        logic [63:0]  x;
        s = m_perm({IV, k, n});
        s = m_perm(s) ^ {a, 128'h0, k};
        s = m_perm(s);
        s[0] = ~s[0];
        x = s[319:256] ^ din;
        dout = x;
        s[319:256] = dec ? din : x;
        s = m_perm(s);
        s[255:128] = s[255:128] ^ k;
        s = m_perm(m_perm(s));
        tag = s[127:0] ^ k;
    endfunction

    function automatic vec_t mk(input logic [127:0] k, input logic [127:0] n,
                                input logic [63:0] a, input logic [63:0] c, input logic [127:0] t);
        vec_t v;
        logic [63:0] pp;
        logic [127:0] tg;
        m_ascon(k, n, a, c, 1'b1, pp, tg);
        v.k = k; v.n = n; v.a = a; v.c = c; v.t = t;
        v.ev = (tg == t);
        v.ep = v.ev ? pp : 64'h0;
        v.etc = tg;
        return v;
    endfunction

    function automatic logic [127:0] r128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic st);
        bus.SK = v.k; bus.N = v.n; bus.A = v.a; bus.C = v.c; bus.T = v.t;
        bus.start = st;
    endtask

    task automatic scramble();
        bus.SK = r128(); bus.N = r128(); bus.T = r128();
        bus.A = {$urandom(), $urandom()}; bus.C = {$urandom(), $urandom()};
    endtask

    task automatic chk_result(input string nm, input vec_t v);
        chk({nm, "_valid"}, 128'(bus.valid), 128'(v.ev));
        chk({nm, "_P"}, 128'(bus.P), 128'(v.ep));
        chk({nm, "_Tc"}, bus.Tc, v.etc);
    endtask

    task automatic do_run(input vec_t v, input string nm);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        drive(v, 1'b1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble();
        chk({nm, "_busy_rise"}, 128'(bus.busy), 128'd1);
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
        chk({nm, "_latency"}, 128'(lat), 128'd6);
        chk({nm, "_busy_held"}, 128'(busy_ok), 128'd1);
        chk({nm, "_busy_at_done"}, 128'(bus.busy), 128'd0);
        chk_result(nm, v);
        @(posedge clk);
        #1;
        chk({nm, "_done_pulse"}, 128'(bus.done), 128'd0);
        chk({nm, "_P_held"}, 128'(bus.P), 128'(v.ep));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [12];
        logic [127:0] K0;
        logic [63:0]  A0, P0, c0, cx;
        logic [127:0] t0, tx;
        int           ndone, done_k;
        logic [63:0]  cap_p;
        logic [127:0] cap_tc;
        logic         cap_v;

        K0 = 128'h000102030405060708090a0b0c0d0e0f;
        A0 = 64'h0001020304050607;
        P0 = 64'h08090a0b0c0d0e0f;
        m_ascon(K0, K0, A0, P0, 1'b0, c0, t0);
        tbl[0] = mk(K0, K0, A0, c0, t0);
        tbl[0].ev = 1'b1; tbl[0].ep = P0; tbl[0].etc = t0;
        tbl[1] = mk(K0, K0, A0, c0, t0 ^ 128'h1);
        tbl[1].etc = t0;
        tbl[2] = mk(K0, K0, A0, c0 ^ {1'b1, 63'h0}, t0);
        tbl[3] = mk(K0, K0, A0 ^ 64'h1, c0, t0);
        for (int i = 4; i < 12; i++) begin
            logic [127:0] rk, rn;
            logic [63:0]  ra, rp;
            rk = r128(); rn = r128(); ra = {$urandom(), $urandom()}; rp = {$urandom(), $urandom()};
            m_ascon(rk, rn, ra, rp, 1'b0, cx, tx);
            if (i % 2 == 1) tx = tx ^ (128'h1 << $urandom_range(127, 0));
            tbl[i] = mk(rk, rn, ra, cx, tx);
            if (i % 2 == 0) tbl[i].ep = rp;
        end

        reset = 1'b1;
        drive(tbl[0], 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_done", 128'(bus.done), 128'd0);
        chk("rst_valid", 128'(bus.valid), 128'd0);
        chk("rst_P", 128'(bus.P), 128'd0);
        chk("rst_Tc", bus.Tc, 128'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_run(tbl[i], $sformatf("vec%0d", i));
            if (!tbl[i].ev) begin
                n_checks++;
                if (bus.Tc === tbl[i].t) begin
                    n_err++;
                    $display("FAIL vec%0d_Tc_ne_T: actual %h required value other than %h", i, bus.Tc, tbl[i].t);
                end
            end
        end

        // start pulses at E2 and E4 must be ignored
        @(negedge clk);
        drive(tbl[0], 1'b1);
        @(posedge clk);
        ndone = 0; done_k = 0; cap_p = '0; cap_tc = '0; cap_v = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            scramble();
            bus.start = (k == 2 || k == 4);
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                done_k = k;
                cap_p = bus.P; cap_tc = bus.Tc; cap_v = bus.valid;
            end
        end
        chk("busy_start_ndone", 128'(ndone), 128'd1);
        chk("busy_start_edge", 128'(done_k), 128'd6);
        chk("busy_start_P", 128'(cap_p), 128'(P0));
        chk("busy_start_Tc", cap_tc, t0);
        chk("busy_start_valid", 128'(cap_v), 128'd1);
        chk("busy_start_idle", 128'(bus.busy), 128'd0);

        // reset sampled at E4 aborts the run
        @(negedge clk);
        drive(tbl[0], 1'b1);
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 128'(bus.busy), 128'd0);
        chk("abort_done", 128'(bus.done), 128'd0);
        chk("abort_valid", 128'(bus.valid), 128'd0);
        chk("abort_P", 128'(bus.P), 128'd0);
        chk("abort_Tc", bus.Tc, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 128'(ndone), 128'd0);
        do_run(tbl[0], "after_abort");

        // start together with reset is not accepted
        @(negedge clk);
        reset = 1'b1;
        drive(tbl[0], 1'b1);
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_start_busy", 128'(bus.busy), 128'd0);
        chk("rst_start_valid", 128'(bus.valid), 128'd0);

        // start held high: runs accepted at E0, E7, E14
        @(negedge clk);
        drive(tbl[0], 1'b1);
        @(posedge clk);
        ndone = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k <= 7)       drive(tbl[1], 1'b1);
            else if (k <= 14) drive(tbl[2], 1'b1);
            else              drive(tbl[2], 1'b0);
            @(posedge clk);
            #1;
            if (bus.done) begin
                chk($sformatf("b2b%0d_edge", ndone), 128'(k), 128'(6 + 7 * ndone));
                if (ndone < 3) chk_result($sformatf("b2b%0d", ndone), tbl[ndone]);
                ndone++;
            end
        end
        chk("b2b_ndone", 128'(ndone), 128'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
